// File: rtl/demux_sched_pkg.sv
// Shared constants for the demux_3x8 round-robin scheduler: state encoding and default sizes.
// The optional hold timeout is enabled with DEMUX_SCHED_TIMEOUT_EN (see demux_rr_sched).
package demux_sched_pkg;

   localparam int NREQ_DEF     = 8;
   localparam int IDX_W_DEF    = 3;
   localparam int MAX_HOLD_DEF = 16;
   localparam int CNT_W_DEF    = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick over 8 requesters: rotate by ptr, find the
// lowest set bit, then add ptr back so the search starts at ptr and wraps.
module rr_pick8
   import demux_sched_pkg::*;
(
   input  logic [7:0] req,
   input  logic [2:0] ptr,
   output logic [2:0] winner,
   output logic       any_req
);

   logic [15:0] w_dbl;
   logic [7:0]  w_rot;
   logic [2:0]  w_off;

   assign w_dbl   = {req, req} >> ptr;
   assign w_rot   = w_dbl[7:0];
   assign any_req = |req;

   // Scan downward so the lowest set bit of the rotated vector wins.
   always_comb begin
      w_off = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (w_rot[i]) w_off = 3'(i);
      end
   end

   assign winner = ptr + w_off;

endmodule

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler driving the select of demux_3x8; grants are held until release.
// Define DEMUX_SCHED_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles.
module demux_rr_sched
   import demux_sched_pkg::*;
#(
   parameter int NREQ     = NREQ_DEF,
   parameter int IDX_W    = IDX_W_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   parameter int CNT_W    = CNT_W_DEF
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   output logic [IDX_W-1:0] sel,
   output logic             sel_valid,
   output logic [NREQ-1:0]  gnt,
   output logic             busy,
   output logic             timeout
);

   state_t           r_state;
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] r_sel;
   logic             r_sel_valid;
   logic [NREQ-1:0]  r_gnt;
   logic             r_busy;
   logic             r_timeout;

   logic [IDX_W-1:0] w_winner;
   logic             w_any;
   logic             w_hold_req;
   logic [NREQ-1:0]  w_onehot;

   rr_pick8 u_pick (
      .req     (req),
      .ptr     (r_ptr),
      .winner  (w_winner),
      .any_req (w_any)
   );

   assign w_hold_req = req[r_sel];
   assign w_onehot   = NREQ'(1) << w_winner;

`ifdef DEMUX_SCHED_TIMEOUT_EN
   logic [CNT_W-1:0] r_cnt;
   logic             w_limit;

   assign w_limit = (r_cnt == CNT_W'(MAX_HOLD - 1));
`else
   logic [63:0] w_unused_cfg;

   assign w_unused_cfg = {MAX_HOLD, CNT_W};
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_sel       <= '0;
         r_sel_valid <= 1'b0;
         r_gnt       <= '0;
         r_busy      <= 1'b0;
         r_timeout   <= 1'b0;
`ifdef DEMUX_SCHED_TIMEOUT_EN
         r_cnt       <= '0;
`endif
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state     <= S_GRANT;
                  r_sel       <= w_winner;
                  r_sel_valid <= 1'b1;
                  r_gnt       <= w_onehot;
                  r_busy      <= 1'b1;
`ifdef DEMUX_SCHED_TIMEOUT_EN
                  r_cnt       <= '0;
`endif
               end
            end
            S_GRANT: begin
               // A release on the limit cycle wins over the timeout.
               if (!w_hold_req) begin
                  r_state     <= S_GAP;
                  r_sel_valid <= 1'b0;
                  r_gnt       <= '0;
                  r_ptr       <= r_sel + 1'b1;
`ifdef DEMUX_SCHED_TIMEOUT_EN
               end else if (w_limit) begin
                  r_state     <= S_GAP;
                  r_sel_valid <= 1'b0;
                  r_gnt       <= '0;
                  r_ptr       <= r_sel + 1'b1;
                  r_timeout   <= 1'b1;
               end else begin
                  r_cnt       <= r_cnt + 1'b1;
`endif
               end
            end
            S_GAP: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state     <= S_IDLE;
               r_sel_valid <= 1'b0;
               r_gnt       <= '0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign sel       = r_sel;
   assign sel_valid = r_sel_valid;
   assign gnt       = r_gnt;
   assign busy      = r_busy;
   assign timeout   = r_timeout;

endmodule

// File: doc/demux_rr_sched.md
Name: demux_rr_sched

Overview:
- Round-robin scheduler that shares the 8-output demux_3x8 between eight requesters.
- Arbitrates the req vector and drives the demux's 3-bit select (sel) with a registered index.
- Holds each grant until that requester drops its request, or until an optional hold timeout expires.
- Sits directly in front of demux_3x8; sel connects to the demux's in port.

Parameters:
- NREQ, 8, number of requesters; fixed by the demux width, not intended to be overridden.
- IDX_W, 3, width of the select index (log2 of NREQ).
- MAX_HOLD, 16, maximum number of GRANT cycles per grant; used only when the timeout feature is compiled in; legal range 2..255.
- CNT_W, 8, width of the hold counter.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req  input  8  request vector; bit i is requester i; level-sensitive.
- sel  output  3  index of the granted requester; drives demux_3x8 in.
- sel_valid  output  1  high while a grant is active; sel is meaningful only when high.
- gnt  output  8  one-hot grant, equal to 1<<sel when sel_valid, else 0.
- busy  output  1  high in the GRANT and GAP states.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset: while rst_n is low at a rising clk edge, the block enters IDLE and clears its registers.
  - Outputs after reset: sel=0, sel_valid=0, gnt=0, busy=0, timeout=0.
  - Internal state after reset: ptr=0, hold counter=0.
  - Reset asserted mid-grant revokes the grant on that same edge.
- All outputs are registered; there is no combinational path from req to any output.
- States are IDLE, GRANT and GAP.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner: the first set bit of req searching ptr, ptr+1, …, wrapping mod 8.
  - Next edge: sel=winner, sel_valid=1, gnt=one-hot, state=GRANT, hold counter=0.
  - Latency from req sampled in IDLE to sel_valid high is 1 cycle.
- GRANT:
  - While req[sel] stays high, remain in GRANT; sel is stable and the counter increments each cycle.
  - Requests from other requesters are ignored while in GRANT.
  - If req[sel] is sampled low: next edge state=GAP, sel_valid=0, gnt=0, ptr=(sel+1) mod 8.
  - sel keeps its last value in GAP (it is don't-care, but held to avoid demux glitching).
- GAP:
  - Exactly one cycle with no grant, guaranteeing a dead cycle between demux outputs.
  - Next state is always IDLE; arbitration happens in IDLE.
  - Grant-to-grant turnaround is therefore 2 idle cycles (GAP plus IDLE).
- Wrap-around: ptr=7 followed by a release gives ptr=0.
  - The requester just served has lowest priority in the next arbitration.
- Simultaneous events: req[sel] dropping on the same cycle the timeout limit is reached counts as a normal release, so timeout stays 0.
- busy = (state != IDLE).

Optional Feature:
- Macro: DEMUX_SCHED_TIMEOUT_EN.
- Defined:
  - In GRANT, when the hold counter equals MAX_HOLD-1 and req[sel] is still high, the next edge forces state=GAP.
  - On that edge: sel_valid=0, ptr=(sel+1) mod 8, timeout=1 for one cycle.
  - A grant lasts at most MAX_HOLD cycles.
  - The requester must re-arbitrate; it is not re-granted ahead of others.
- Undefined:
  - The hold counter is not synthesised.
  - timeout is tied to 0.
  - A grant persists for as long as req[sel] is held high.

Decomposition:
- Shared package demux_sched_pkg holds:
  - state encoding constants: S_IDLE=2'd0, S_GRANT=2'd1, S_GAP=2'd2;
  - default NREQ, IDX_W and MAX_HOLD constants.
- One sub-module: rr_pick8, a purely combinational block.
  - Inputs: req[7:0] and ptr[2:0].
  - Outputs: winner[2:0] and any_req.
  - Implementation: rotate, then priority encode, then un-rotate.
- The FSM, ptr, counter and output registers live in demux_rr_sched.
- demux_3x8 is instantiated only at integration level, not inside this block.

Test Plan:
- Reset: drive rst_n=0 for 2 clocks with req=8'hFF → sel=0, sel_valid=0, gnt=0, busy=0; first grant after release goes to requester 0 (sel=0, gnt=8'h01).
- Single requester: req=8'h10 held 5 cycles then dropped → sel=4 one cycle after req; gnt=8'h10 for 5 cycles; GAP cycle with sel_valid=0; ptr becomes 5.
- Round robin: req=8'hFF constant, each grantee dropping its req after 2 cycles and reasserting it immediately → grant order 0,1,2,…,7,0; each grant separated by one GAP cycle and one IDLE cycle.
- Wrap priority: ptr=6 with req=8'h81 → grant 7, then after release grant 0; req=8'h41 with ptr=7 → grant 0 first.
- Timeout (DEMUX_SCHED_TIMEOUT_EN defined, MAX_HOLD=4): req=8'h0C held high → sel=2 for exactly 4 cycles; timeout=1 for 1 cycle; after GAP and IDLE, sel=3. Without the macro, sel stays 2 indefinitely and timeout stays 0.
- Reset mid-grant: rst_n=0 for one cycle while sel=5 is granted → the next edge gives sel_valid=0, gnt=0, ptr=0.
